// File: rtl/morse_tx.sv
// Morse-code key-line transmitter: sends one letter per accepted start, framing
// it with either a trailing gap (mode 0) or a long end mark (mode 1).
module morse_tx #(
  parameter int unsigned DOT_CYC      = 100,
  parameter int unsigned DASH_CYC     = 3000,
  parameter int unsigned GAP_CYC      = 100,
  parameter int unsigned END_MARK_CYC = 6000,
  parameter int unsigned END_GAP_CYC  = 6100,
  parameter int unsigned REV_CYC      = 20000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] char_code,
  input  logic       mode,
  output logic       dout,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, REV_MARK, REV_GAP, MARK, SPACE, END_MARK, END_SPACE, END_GAP
  } state_t;

  localparam logic [CNT_W-1:0] DOT_L  = CNT_W'(DOT_CYC - 1);
  localparam logic [CNT_W-1:0] DASH_L = CNT_W'(DASH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_L  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] ENDM_L = CNT_W'(END_MARK_CYC - 1);
  localparam logic [CNT_W-1:0] ENDG_L = CNT_W'(END_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] REV_L  = CNT_W'(REV_CYC - 1);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [3:0]       pat, nxt_pat;
  logic [1:0]       rem, nxt_rem;
  logic             let_mode, nxt_mode;
  logic             cur_mode, nxt_cur;
  logic [5:0]       rom_q;
  logic             valid_code;

  // {elements after the first, pattern left-aligned}; 1 = dash, MSB sent first
  function automatic logic [5:0] rom(input logic [4:0] c);
    case (c)
      5'd0:    rom = {2'd1, 4'b0100};
      5'd1:    rom = {2'd3, 4'b1000};
      5'd2:    rom = {2'd3, 4'b1010};
      5'd3:    rom = {2'd2, 4'b1000};
      5'd4:    rom = {2'd0, 4'b0000};
      5'd5:    rom = {2'd3, 4'b0010};
      5'd6:    rom = {2'd2, 4'b1100};
      5'd7:    rom = {2'd3, 4'b0000};
      5'd8:    rom = {2'd1, 4'b0000};
      5'd9:    rom = {2'd3, 4'b0111};
      5'd10:   rom = {2'd2, 4'b1010};
      5'd11:   rom = {2'd3, 4'b0100};
      5'd12:   rom = {2'd1, 4'b1100};
      5'd13:   rom = {2'd1, 4'b1000};
      5'd14:   rom = {2'd2, 4'b1110};
      5'd15:   rom = {2'd3, 4'b0110};
      5'd16:   rom = {2'd3, 4'b1101};
      5'd17:   rom = {2'd2, 4'b0100};
      5'd18:   rom = {2'd2, 4'b0000};
      5'd19:   rom = {2'd0, 4'b1000};
      5'd20:   rom = {2'd2, 4'b0010};
      5'd21:   rom = {2'd3, 4'b0001};
      5'd22:   rom = {2'd2, 4'b0110};
      5'd23:   rom = {2'd3, 4'b1001};
      5'd24:   rom = {2'd3, 4'b1011};
      5'd25:   rom = {2'd3, 4'b1100};
      default: rom = '0;
    endcase
  endfunction

  assign rom_q      = rom(char_code);
  assign valid_code = (char_code <= 5'd25);

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_pat   = pat;
    nxt_rem   = rem;
    nxt_mode  = let_mode;
    nxt_cur   = cur_mode;
    if (state == IDLE) begin
      if (start && valid_code) begin
        nxt_pat  = rom_q[3:0];
        nxt_rem  = rom_q[5:4];
        nxt_mode = mode;
        if (mode != cur_mode) begin
          nxt_state = REV_MARK;
          nxt_cnt   = REV_L;
        end else begin
          nxt_state = MARK;
          nxt_cnt   = rom_q[3] ? DASH_L : DOT_L;
        end
      end
    end else if (cnt != '0) begin
      nxt_cnt = cnt - 1'b1;
    end else begin
      // interval expired: load the next interval so no dead cycle appears
      case (state)
        REV_MARK: begin
          nxt_state = REV_GAP;
          nxt_cnt   = GAP_L;
        end
        REV_GAP: begin
          nxt_cur   = let_mode;
          nxt_state = MARK;
          nxt_cnt   = pat[3] ? DASH_L : DOT_L;
        end
        MARK: begin
          nxt_state = SPACE;
          nxt_cnt   = GAP_L;
        end
        SPACE: begin
          if (rem != 2'd0) begin
            nxt_rem   = rem - 2'd1;
            nxt_pat   = {pat[2:0], 1'b0};
            nxt_state = MARK;
            nxt_cnt   = pat[2] ? DASH_L : DOT_L;
          end else if (let_mode) begin
            nxt_state = END_MARK;
            nxt_cnt   = ENDM_L;
          end else begin
            nxt_state = END_GAP;
            nxt_cnt   = ENDG_L;
          end
        end
        END_MARK: begin
          nxt_state = END_SPACE;
          nxt_cnt   = GAP_L;
        end
        default: begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // outputs are registered from the next-state view so they line up with state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pat      <= '0;
      rem      <= '0;
      let_mode <= 1'b0;
      cur_mode <= 1'b0;
      dout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      pat      <= nxt_pat;
      rem      <= nxt_rem;
      let_mode <= nxt_mode;
      cur_mode <= nxt_cur;
      dout     <= (nxt_state == REV_MARK) || (nxt_state == MARK) || (nxt_state == END_MARK);
      busy     <= (nxt_state != IDLE);
      done     <= ((nxt_state == END_SPACE) || (nxt_state == END_GAP)) && (nxt_cnt == '0);
      err      <= (state == IDLE) && start && !valid_code;
    end
  end

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx using short interval lengths; expected key-line
// run lengths are built from each letter's dot/dash string.
module tb_morse_tx;

  localparam int DOT  = 1;
  localparam int DASH = 4;
  localparam int GAP  = 2;
  localparam int ENDM = 6;
  localparam int ENDG = 9;
  localparam int REV  = 12;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] char_code;
  logic       mode;
  logic       dout;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  morse_tx #(
    .DOT_CYC(DOT),
    .DASH_CYC(DASH),
    .GAP_CYC(GAP),
    .END_MARK_CYC(ENDM),
    .END_GAP_CYC(ENDG),
    .REV_CYC(REV),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .char_code(char_code),
    .mode(mode),
    .dout(dout),
    .busy(busy),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sends one letter and compares the dout run lengths, done and busy timing.
  // poke > 0 raises start with another code on that cycle of the letter.
  task automatic send(input string tag, input logic [4:0] code, input logic m,
                      input string pat, input bit sw, input int poke);
    int exp_runs[$];
    int runs[$];
    int total;
    int n;
    int len;
    int done_cnt;
    int done_at;
    int err_cnt;
    int busy_low;
    bit lvl;
    bit finished;

    if (sw) begin
      exp_runs.push_back(REV);
      exp_runs.push_back(GAP);
    end
    for (int i = 0; i < pat.len(); i++) begin
      exp_runs.push_back((pat[i] == "-") ? DASH : DOT);
      exp_runs.push_back(GAP);
    end
    if (m) begin
      exp_runs.push_back(ENDM);
      exp_runs.push_back(GAP);
    end else begin
      exp_runs[exp_runs.size()-1] = exp_runs[exp_runs.size()-1] + ENDG;
    end
    total = 0;
    foreach (exp_runs[i]) total += exp_runs[i];

    @(negedge clk);
    start     = 1'b1;
    char_code = code;
    mode      = m;
    @(negedge clk);
    start     = 1'b0;
    char_code = 5'd21;
    mode      = ~m;

    n = 0; len = 0; lvl = 1'b0; finished = 1'b0;
    done_cnt = 0; done_at = 0; err_cnt = 0; busy_low = 0;
    while (!finished && n < 300) begin
      n++;
      if (n == 1) check({tag, "_first_dout"}, int'(dout), 1);
      if (err) err_cnt++;
      if (!busy) begin
        finished = 1'b1;
        busy_low = n;
        check({tag, "_idle_dout"}, int'(dout), 0);
      end else begin
        if (done) begin
          done_cnt++;
          done_at = n;
        end
        if (n == 1) begin
          lvl = dout;
          len = 1;
        end else if (dout == lvl) begin
          len++;
        end else begin
          runs.push_back(len);
          lvl = dout;
          len = 1;
        end
      end
      if (poke != 0 && n == poke) begin
        start     = 1'b1;
        char_code = 5'd19;
      end else begin
        start = 1'b0;
      end
      if (!finished) @(negedge clk);
    end
    start = 1'b0;
    if (!finished) check({tag, "_timeout"}, 0, 1);
    if (len > 0) runs.push_back(len);

    check({tag, "_run_count"}, runs.size(), exp_runs.size());
    for (int i = 0; i < runs.size() && i < exp_runs.size(); i++)
      check($sformatf("%s_run%0d", tag, i), runs[i], exp_runs[i]);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_at, total);
    check({tag, "_busy_low_cycle"}, busy_low, total + 1);
    check({tag, "_err_quiet"}, err_cnt, 0);
  endtask

  initial begin
    int done_seen;
    rst = 1'b0; start = 1'b0; char_code = '0; mode = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_dout", int'(dout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err",  int'(err),  0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_outputs", int'({dout, busy, done, err}), 0);

    send("E_m0", 5'd4,  1'b0, ".",    1'b0, 0);
    send("H_m1", 5'd7,  1'b1, "....", 1'b1, 0);
    send("O_m1", 5'd14, 1'b1, "---",  1'b0, 0);
    send("L_m0", 5'd11, 1'b0, ".-..", 1'b1, 0);

    // invalid code: one-cycle err, nothing else moves
    @(negedge clk);
    start = 1'b1; char_code = 5'd27; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("inv_err_k1", int'(err), 1);
    check("inv_dout",   int'(dout), 0);
    check("inv_busy",   int'(busy), 0);
    check("inv_done",   int'(done), 0);
    @(negedge clk);
    check("inv_err_k2",  int'(err), 0);
    check("inv_busy_k2", int'(busy), 0);

    send("A_poke", 5'd0, 1'b0, ".-", 1'b0, 3);

    // reset asserted in the middle of a dash
    @(negedge clk);
    start = 1'b1; char_code = 5'd19; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_dash_high", int'(dout), 1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_dout", int'(dout), 0);
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || dout || busy) done_seen++;
    end
    check("lost_letter_quiet", done_seen, 0);

    // cur_mode was cleared, so a mode-1 letter needs the switch mark again
    send("E_m1_after_rst", 5'd4, 1'b1, ".", 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
